// File: rtl/bcd_seg_pkg.sv
// Shared segment constants for the BCD scan display driver.
// Bit k of a pattern drives segment a+k; patterns are active-high.
package bcd_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SA = 7'(1 << SEG_A);
  localparam logic [6:0] SB = 7'(1 << SEG_B);
  localparam logic [6:0] SC = 7'(1 << SEG_C);
  localparam logic [6:0] SD = 7'(1 << SEG_D);
  localparam logic [6:0] SE = 7'(1 << SEG_E);
  localparam logic [6:0] SF = 7'(1 << SEG_F);
  localparam logic [6:0] SG = 7'(1 << SEG_G);

  localparam logic [6:0] SEG_0     = SA | SB | SC | SD | SE | SF;
  localparam logic [6:0] SEG_1     = SB | SC;
  localparam logic [6:0] SEG_2     = SA | SB | SD | SE | SG;
  localparam logic [6:0] SEG_3     = SA | SB | SC | SD | SG;
  localparam logic [6:0] SEG_4     = SB | SC | SF | SG;
  localparam logic [6:0] SEG_5     = SA | SC | SD | SF | SG;
  localparam logic [6:0] SEG_6     = SA | SC | SD | SE | SF | SG;
  localparam logic [6:0] SEG_7     = SA | SB | SC;
  localparam logic [6:0] SEG_8     = SA | SB | SC | SD | SE | SF | SG;
  localparam logic [6:0] SEG_9     = SA | SB | SC | SD | SF | SG;
  localparam logic [6:0] SEG_DASH  = SG;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment pattern decoder.
// Non-decimal codes show a dash so corrupt input is visible on the display.
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with a tear-free double buffer.
// Define BCD_SEG_LZB_EN to enable leading-zero blanking.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done,
  output logic              pending
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NDIG);

  logic [PW-1:0]     pcnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] shadow;
  logic [4*NDIG-1:0] active;
  logic [4*NDIG-1:0] active_nxt;
  logic [3:0]        digit;
  logic [6:0]        dec_seg;
  logic [NDIG-1:0]   an_nxt;
  logic              blank;
  logic              pcnt_wrap;
  logic              idx_last;

  assign pcnt_wrap = (pcnt == PW'(PRESCALE - 1));
  assign idx_last  = (idx == IW'(NDIG - 1));

  // The frame_done cycle is the frame boundary; a same-cycle load bypasses the
  // shadow, and decode is fed from the post-boundary value so digit 0 is never stale.
  always_comb begin
    active_nxt = active;
    if (frame_done) begin
      if (load)         active_nxt = bcd_in;
      else if (pending) active_nxt = shadow;
    end
  end

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < NDIG; i++)
      if (idx == IW'(i)) digit = active_nxt[4*i +: 4];
  end

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

`ifdef BCD_SEG_LZB_EN
  logic zrun;
  always_comb begin
    zrun  = 1'b1;
    blank = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zrun = zrun & (active_nxt[4*i +: 4] == 4'd0);
      if (zrun && (idx == IW'(i))) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < NDIG; i++)
      if (!blank && (idx == IW'(i))) an_nxt[i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      pcnt <= pcnt_wrap ? '0 : pcnt + 1'b1;
      if (pcnt_wrap) idx <= idx_last ? '0 : idx + 1'b1;
      frame_done <= pcnt_wrap && idx_last;
      active     <= active_nxt;
      if (load) begin
        shadow  <= bcd_in;
        pending <= !frame_done;
      end else if (frame_done) begin
        pending <= 1'b0;
      end
      seg <= blank ? SEG_BLANK : dec_seg;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (NDIG = 4, PRESCALE = 4).
// Honours BCD_SEG_LZB_EN when the design is built with leading-zero blanking.
module tb_bcd_seg_scan;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int FRAME    = NDIG * PRESCALE;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        load   = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: edges since reset release plus displayed/buffered values.
  int          e;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pending;

  logic [6:0] cap [4];
  bit         lit [4];
  logic       first_pend;

  typedef struct {
    logic [15:0]     val;
    logic [3:0][6:0] s;
  } vec_t;
  vec_t vecs [6];

  bcd_seg_scan #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .bcd_in     (bcd_in),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [6:0] ref_seg(logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic bit ref_blank(logic [15:0] a, int d);
`ifdef BCD_SEG_LZB_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < NDIG; j++)
      if (a[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    e         = 0;
    m_active  = 16'h0;
    m_shadow  = 16'h0;
    m_pending = 1'b0;
  endtask

  task automatic tick();
    bit         fd;
    int         d;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    fd = (e > 0) && (e % FRAME == 0);
    @(posedge clk);
    #1;
    if (load && fd) begin
      m_active  = bcd_in;
      m_shadow  = bcd_in;
      m_pending = 1'b0;
    end else begin
      if (fd && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (load) begin
        m_shadow  = bcd_in;
        m_pending = 1'b1;
      end
    end
    e++;
    d = ((e - 1) / PRESCALE) % NDIG;
    exp_an = 4'hF;
    if (ref_blank(m_active, d)) exp_seg = 7'h00;
    else begin
      exp_an[d] = 1'b0;
      exp_seg   = ref_seg(m_active[4*d +: 4]);
    end
    chk("seg", seg, exp_seg);
    chk("an", an, exp_an);
    chk("frame_done", frame_done, (e % FRAME == 0));
    chk("pending", pending, m_pending);
  endtask

  task automatic do_load(logic [15:0] v);
    bcd_in = v;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("wait_frame_done", frame_done, 1);
  endtask

  task automatic capture();
    for (int d = 0; d < 4; d++) begin
      lit[d] = 1'b0;
      cap[d] = 7'h00;
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      load = 1'b0;
      if (c == 0) first_pend = pending;
      for (int d = 0; d < 4; d++)
        if (an[d] === 1'b0) begin
          lit[d] = 1'b1;
          cap[d] = seg;
        end
    end
  endtask

  // An expected pattern of 7'h00 means the digit must never be enabled.
  task automatic frame_expect(string nm, logic [3:0][6:0] s);
    for (int d = 0; d < 4; d++) begin
      if (s[d] == 7'h00) chk({nm, " blank"}, lit[d], 0);
      else begin
        chk({nm, " lit"}, lit[d], 1);
        chk({nm, " seg"}, cap[d], s[d]);
      end
    end
  endtask

  initial begin
    logic [3:0]      an_seq [4];
    logic [3:0][6:0] s_2222;
    logic [3:0][6:0] s_0009;

    vecs[0] = '{val: 16'h1234, s: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{val: 16'h5678, s: {7'h6D, 7'h7D, 7'h07, 7'h7F}};
    vecs[2] = '{val: 16'h9090, s: {7'h6F, 7'h3F, 7'h6F, 7'h3F}};
`ifdef BCD_SEG_LZB_EN
    vecs[3] = '{val: 16'h00AB, s: {7'h00, 7'h00, 7'h40, 7'h40}};
    vecs[4] = '{val: 16'h0010, s: {7'h00, 7'h00, 7'h06, 7'h3F}};
    vecs[5] = '{val: 16'h0000, s: {7'h00, 7'h00, 7'h00, 7'h3F}};
    an_seq  = '{4'hE, 4'hF, 4'hF, 4'hF};
    s_0009  = {7'h00, 7'h00, 7'h00, 7'h6F};
`else
    vecs[3] = '{val: 16'h00AB, s: {7'h3F, 7'h3F, 7'h40, 7'h40}};
    vecs[4] = '{val: 16'h0010, s: {7'h3F, 7'h3F, 7'h06, 7'h3F}};
    vecs[5] = '{val: 16'h0000, s: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    an_seq  = '{4'hE, 4'hD, 4'hB, 4'h7};
    s_0009  = {7'h3F, 7'h3F, 7'h3F, 7'h6F};
`endif
    s_2222 = {7'h5B, 7'h5B, 7'h5B, 7'h5B};

    // Reset: async assertion, outputs blank without a clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h00);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pending", pending, 0);
    repeat (3) @(posedge clk);
    #1 chk("rst_an_held", an, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      chk("scan_an", an, an_seq[(i / PRESCALE) % NDIG]);
      chk("scan_frame_done", frame_done, (i % FRAME == FRAME - 1));
    end

    // Load mid-frame, commit at the next boundary.
    foreach (vecs[v]) begin
      wait_fd();
      repeat (5) tick();
      do_load(vecs[v].val);
      chk("pending_set", pending, 1);
      wait_fd();
      chk("pending_until_boundary", pending, 1);
      capture();
      frame_expect($sformatf("frame_%04h", vecs[v].val), vecs[v].s);
    end

    // Latest load in a frame wins.
    wait_fd();
    repeat (3) tick();
    do_load(16'h1111);
    repeat (2) tick();
    do_load(16'h2222);
    wait_fd();
    capture();
    frame_expect("latest_wins", s_2222);

    // Load on the frame_done cycle bypasses the shadow.
    wait_fd();
    bcd_in = 16'h0009;
    load   = 1'b1;
    capture();
    chk("bypass_pending", first_pend, 0);
    frame_expect("bypass", s_0009);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      load   = ($urandom_range(0, 5) == 0);
      bcd_in = 16'($urandom);
      tick();
    end
    load = 1'b0;

    // Reset during digit 2 with a load pending.
    wait_fd();
    repeat (9) tick();
    do_load(16'h4321);
    chk("mid_pending", pending, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_seg", seg, 7'h00);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_pending", pending, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    capture();
    frame_expect("after_reset", vecs[5].s);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
